multiword_subtractor: RTL and testbench



---
 rtl/multiword_subtractor_if.sv | 36 +++
 rtl/multiword_subtractor.sv | 133 +++++++++++++
 tb/tb_multiword_subtractor.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiword_subtractor_if.sv
// Request/result bundle for multiword_subtractor; the ovf signal exists only when SUB_SIGNED_OVF_EN is defined.
interface multiword_subtractor_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_WORDS  = 4
);
   localparam int TW = DATA_WIDTH * NUM_WORDS;

   logic          start;
   logic [TW-1:0] op_a;
   logic [TW-1:0] op_b;
   logic          borrow_in;
   logic          busy;
   logic          done;
   logic [TW-1:0] diff;
   logic          borrow_out;
   logic          zero;
`ifdef SUB_SIGNED_OVF_EN
   logic          ovf;
`endif

   modport master (
      output start, op_a, op_b, borrow_in,
      input  busy, done, diff, borrow_out, zero
`ifdef SUB_SIGNED_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  start, op_a, op_b, borrow_in,
      output busy, done, diff, borrow_out, zero
`ifdef SUB_SIGNED_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/multiword_subtractor.sv
// A - B - borrow_in, one DATA_WIDTH word per clock LSW first; done pulses NUM_WORDS+1 edges after start, start ignored while busy.
// SUB_SIGNED_OVF_EN adds the two's-complement overflow flag ovf.
module multiword_subtractor #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_WORDS  = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   multiword_subtractor_if.slave  bus
);
   localparam int TW = DATA_WIDTH * NUM_WORDS;
   localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  brw_q, brw_d;
   logic [TW-1:0]         a_q, a_d;
   logic [TW-1:0]         b_q, b_d;
   logic [TW-1:0]         diff_q, diff_d;
   logic                  borrow_out_q, borrow_out_d;
   logic                  zero_q, zero_d;
`ifdef SUB_SIGNED_OVF_EN
   logic                  ovf_q, ovf_d;
`endif

   logic [DATA_WIDTH-1:0] a_word, b_word, slice;
   logic                  slice_brw;
   logic                  last_word;

   // The extra MSB of the widened subtraction is the word borrow.
   always_comb begin
      a_word = '0;
      b_word = '0;
      for (int w = 0; w < NUM_WORDS; w++) begin
         if (cnt_q == CW'(w)) begin
            a_word = a_q[w*DATA_WIDTH +: DATA_WIDTH];
            b_word = b_q[w*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      {slice_brw, slice} = {1'b0, a_word} - {1'b0, b_word} - {{DATA_WIDTH{1'b0}}, brw_q};
   end

   assign last_word = (cnt_q == CW'(NUM_WORDS - 1));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      brw_d        = brw_q;
      a_d          = a_q;
      b_d          = b_q;
      diff_d       = diff_q;
      borrow_out_d = borrow_out_q;
      zero_d       = zero_q;
`ifdef SUB_SIGNED_OVF_EN
      ovf_d        = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d      = S_RUN;
               a_d          = bus.op_a;
               b_d          = bus.op_b;
               brw_d        = bus.borrow_in;
               cnt_d        = '0;
               diff_d       = '0;
               borrow_out_d = 1'b0;
               zero_d       = 1'b0;
`ifdef SUB_SIGNED_OVF_EN
               ovf_d        = 1'b0;
`endif
            end
         end
         S_RUN: begin
            for (int w = 0; w < NUM_WORDS; w++) begin
               if (cnt_q == CW'(w)) diff_d[w*DATA_WIDTH +: DATA_WIDTH] = slice;
            end
            brw_d = slice_brw;
            cnt_d = cnt_q + CW'(1);
            if (last_word) begin
               state_d      = S_DONE;
               borrow_out_d = slice_brw;
               zero_d       = (diff_d == '0);
`ifdef SUB_SIGNED_OVF_EN
               ovf_d        = (a_q[TW-1] ^ b_q[TW-1]) & (diff_d[TW-1] ^ a_q[TW-1]);
`endif
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         brw_q        <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         diff_q       <= '0;
         borrow_out_q <= 1'b0;
         zero_q       <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
         ovf_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         brw_q        <= brw_d;
         a_q          <= a_d;
         b_q          <= b_d;
         diff_q       <= diff_d;
         borrow_out_q <= borrow_out_d;
         zero_q       <= zero_d;
`ifdef SUB_SIGNED_OVF_EN
         ovf_q        <= ovf_d;
`endif
      end
   end

   assign bus.busy       = (state_q != S_IDLE);
   assign bus.done       = (state_q == S_DONE);
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_out_q;
   assign bus.zero       = zero_q;
`ifdef SUB_SIGNED_OVF_EN
   assign bus.ovf        = ovf_q;
`endif
endmodule

// File: tb/tb_multiword_subtractor.sv
// Scoreboard bench: a default 8x4 instance and a 4x1 instance, random and directed subtractions against a plain-arithmetic model.
module tb_multiword_subtractor;
   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_fail;

   typedef struct {
      logic [31:0] diff;
      logic        bout;
      logic        zero;
      logic        ovf;
      int          due;
   } e0_t;

   typedef struct {
      logic [3:0] diff;
      logic       bout;
      logic       zero;
      logic       ovf;
      int         due;
   } e1_t;

   e0_t  sb0[$];
   e1_t  sb1[$];
   e0_t  m0, held0;
   e1_t  m1, held1;
   logic prev_done0, prev_done1;

   multiword_subtractor_if #(.DATA_WIDTH(8), .NUM_WORDS(4)) if0 ();
   multiword_subtractor_if #(.DATA_WIDTH(4), .NUM_WORDS(1)) if1 ();

   multiword_subtractor #(.DATA_WIDTH(8), .NUM_WORDS(4)) u0 (.clk_i(clk), .rst_i(rst), .bus(if0));
   multiword_subtractor #(.DATA_WIDTH(4), .NUM_WORDS(1)) u1 (.clk_i(clk), .rst_i(rst), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name, input int act, input int req);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   // Reference: unsigned full-width arithmetic; overflow from operand/result signs.
   function automatic e0_t model0(input logic [31:0] a, input logic [31:0] b, input logic bin, input int due);
      e0_t e;
      longint unsigned ua, ub;
      ua     = 64'(a);
      ub     = 64'(b);
      e.diff = a - b - 32'(bin);
      e.bout = (ua < ub + 64'(bin));
      e.zero = (e.diff == 32'd0);
      e.ovf  = (a[31] != b[31]) && (e.diff[31] != a[31]);
      e.due  = due;
      return e;
   endfunction

   function automatic e1_t model1(input logic [3:0] a, input logic [3:0] b, input logic bin, input int due);
      e1_t e;
      int  r;
      r      = int'(a) - int'(b) - int'(bin);
      e.diff = 4'(r);
      e.bout = (r < 0);
      e.zero = (e.diff == 4'd0);
      e.ovf  = (a[3] != b[3]) && (e.diff[3] != a[3]);
      e.due  = due;
      return e;
   endfunction

   function automatic logic [31:0] rnd_word();
      int sel;
      sel = $urandom_range(0, 5);
      if (sel == 0) return 32'h0000_0000;
      if (sel == 1) return 32'hFFFF_FFFF;
      if (sel == 2) return 32'h8000_0000;
      return 32'($urandom);
   endfunction

   task automatic wait_idle0();
      int g;
      g = 0;
      while ((if0.busy || if0.done) && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) fail_now("idle0_wait_cycles", g, 50);
   endtask

   task automatic issue0(input logic [31:0] a, input logic [31:0] b, input logic bin, input bit nuisance);
      wait_idle0();
      if0.op_a      = a;
      if0.op_b      = b;
      if0.borrow_in = bin;
      if0.start     = 1'b1;
      @(negedge clk);
      if0.start     = 1'b0;
      sb0.push_back(model0(a, b, bin, cyc + 4));
      if0.op_a      = 32'($urandom);
      if0.op_b      = 32'($urandom);
      if0.borrow_in = ~bin;
      if (nuisance) begin
         @(negedge clk);
         if0.start = 1'b1;
         @(negedge clk);
         if0.start = 1'b0;
         @(negedge clk);
         @(negedge clk);
         if0.start = 1'b1;
         @(negedge clk);
         if0.start = 1'b0;
      end
   endtask

   task automatic issue1(input logic [3:0] a, input logic [3:0] b, input logic bin);
      int g;
      g = 0;
      while ((if1.busy || if1.done) && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) fail_now("idle1_wait_cycles", g, 50);
      if1.op_a      = a;
      if1.op_b      = b;
      if1.borrow_in = bin;
      if1.start     = 1'b1;
      @(negedge clk);
      if1.start     = 1'b0;
      sb1.push_back(model1(a, b, bin, cyc + 1));
      if1.op_a      = 4'($urandom);
      if1.op_b      = 4'($urandom);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_done0 = 1'b0;
      end else begin
         if (prev_done0) begin
            chk("done0_pulse_width", 64'(if0.done), 64'(0));
            chk("hold0_diff", 64'(if0.diff), 64'(held0.diff));
            chk("hold0_borrow_out", 64'(if0.borrow_out), 64'(held0.bout));
         end
         if (if0.done) begin
            if (sb0.size() == 0) begin
               fail_now("done0_unexpected", 1, 0);
            end else begin
               m0 = sb0.pop_front();
               chk("diff0", 64'(if0.diff), 64'(m0.diff));
               chk("borrow_out0", 64'(if0.borrow_out), 64'(m0.bout));
               chk("zero0", 64'(if0.zero), 64'(m0.zero));
               chk("latency0_cycle", 64'(cyc), 64'(m0.due));
`ifdef SUB_SIGNED_OVF_EN
               chk("ovf0", 64'(if0.ovf), 64'(m0.ovf));
`endif
               held0 = m0;
            end
         end else if (sb0.size() > 0 && cyc > sb0[0].due + 2) begin
            fail_now("done0_missing_by_cycle", cyc, sb0[0].due);
            void'(sb0.pop_front());
         end
         prev_done0 = if0.done;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         prev_done1 = 1'b0;
      end else begin
         if (prev_done1) begin
            chk("done1_pulse_width", 64'(if1.done), 64'(0));
            chk("hold1_diff", 64'(if1.diff), 64'(held1.diff));
         end
         if (if1.done) begin
            if (sb1.size() == 0) begin
               fail_now("done1_unexpected", 1, 0);
            end else begin
               m1 = sb1.pop_front();
               chk("diff1", 64'(if1.diff), 64'(m1.diff));
               chk("borrow_out1", 64'(if1.borrow_out), 64'(m1.bout));
               chk("zero1", 64'(if1.zero), 64'(m1.zero));
               chk("latency1_cycle", 64'(cyc), 64'(m1.due));
`ifdef SUB_SIGNED_OVF_EN
               chk("ovf1", 64'(if1.ovf), 64'(m1.ovf));
`endif
               held1 = m1;
            end
         end else if (sb1.size() > 0 && cyc > sb1[0].due + 2) begin
            fail_now("done1_missing_by_cycle", cyc, sb1[0].due);
            void'(sb1.pop_front());
         end
         prev_done1 = if1.done;
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy0"}, 64'(if0.busy), 64'(0));
      chk({tag, "_done0"}, 64'(if0.done), 64'(0));
      chk({tag, "_diff0"}, 64'(if0.diff), 64'(0));
      chk({tag, "_borrow_out0"}, 64'(if0.borrow_out), 64'(0));
      chk({tag, "_zero0"}, 64'(if0.zero), 64'(0));
      chk({tag, "_busy1"}, 64'(if1.busy), 64'(0));
      chk({tag, "_diff1"}, 64'(if1.diff), 64'(0));
`ifdef SUB_SIGNED_OVF_EN
      chk({tag, "_ovf0"}, 64'(if0.ovf), 64'(0));
`endif
   endtask

   initial begin
      int g;
      n_checks      = 0;
      n_fail        = 0;
      cyc           = 0;
      rst           = 1'b1;
      if0.start     = 1'b0;
      if0.op_a      = '0;
      if0.op_b      = '0;
      if0.borrow_in = 1'b0;
      if1.start     = 1'b0;
      if1.op_a      = '0;
      if1.op_b      = '0;
      if1.borrow_in = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      issue0(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b0);
      issue0(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
      issue0(32'h1234_5678, 32'h1234_5677, 1'b1, 1'b1);
      issue0(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
      issue0(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);

      // Abort mid-operation: partial words are already in diff when reset hits.
      wait_idle0();
      if0.op_a  = 32'hFFFF_FFFF;
      if0.op_b  = 32'h0000_0001;
      if0.borrow_in = 1'b0;
      if0.start = 1'b1;
      @(negedge clk);
      if0.start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs("abort");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      issue0(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         issue0(rnd_word(), rnd_word(), 1'($urandom), 1'(i % 7 == 3));
      end

      issue1(4'h3, 4'h5, 1'b0);
      issue1(4'h0, 4'h0, 1'b1);
      issue1(4'h7, 4'h7, 1'b0);
      for (int i = 0; i < 60; i++) begin
         issue1(4'($urandom), 4'($urandom), 1'($urandom));
      end

      g = 0;
      while ((sb0.size() > 0 || sb1.size() > 0) && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) fail_now("drain_pending_entries", sb0.size() + sb1.size(), 0);
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
